spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI master controller that sequences byte transfers to up to NUM_SLAVES SPI slave blocks on one shared bus.
- Bus mode is fixed: CPOL=0, CPHA=1, LSB first, 8-bit frames. Shift on the rising SCLK edge, sample on the falling edge.
- Sits between the system-side requester (start/busy/done handshake) and the slave ports (cs_n, sclk, mosi, miso). Generates SCLK from clk through a programmable divider.

Parameters:
- NUM_SLAVES, 2, number of chip-select lines; legal range 1..2^SEL_W.
- SEL_W, 1, width of slave_sel.
- CLK_DIV, 2, clk cycles per SCLK half-period; minimum 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  transfer request; sampled only while busy=0.
- slave_sel  input  SEL_W  target slave index; latched with start.
- tx_data  input  8  byte to send; latched with start.
- rx_data  output  8  last received byte; updated in the done cycle, held otherwise.
- busy  output  1  high from the cycle after accepted start until the done cycle (exclusive).
- done  output  1  one-cycle pulse at the end of a transfer.
- err  output  1  one-cycle pulse when start is rejected for an invalid slave_sel.
- cs_n  output  NUM_SLAVES  active-low chip selects; at most one low at any time.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  master-out serial data.
- miso  input  1  master-in serial data; shared by all slaves.

Behaviour:
- Reset (reset=0, asynchronous, valid at any time including mid-transfer):
  - cs_n all 1, sclk=0, mosi=0, busy=0, done=0, err=0, rx_data=8'h00.
  - FSM returns to IDLE; shift registers and counters cleared.
  - Operation resumes on the first clk edge after reset returns to 1.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - start=1 and slave_sel<NUM_SLAVES: latch tx_data into tx_sh and slave_sel. Next cycle: busy=1, cs_n[sel]=0, sclk=0, go to SETUP.
  - start=1 and slave_sel>=NUM_SLAVES: err=1 for one cycle; no cs_n change; stay in IDLE.
- SETUP:
  - Held for CLK_DIV cycles (CS-to-first-edge setup time).
  - Then go to XFER and perform rising edge 1.
- XFER:
  - Half-period counter 0..CLK_DIV-1; sclk toggles when it wraps.
  - 16 edges total: 8 rising, 8 falling, alternating, starting with rising.
  - On each rising edge: mosi <= tx_sh[0]; tx_sh <= tx_sh>>1.
  - On each falling edge: rx_sh <= {miso, rx_sh[7:1]}.
  - A bit counter (0..8) counts falling edges. After falling edge 8, go to HOLD with sclk=0.
- HOLD:
  - Held for CLK_DIV cycles.
  - Then in one cycle: cs_n all 1, busy=0, done=1, rx_data<=rx_sh, mosi<=0, return to IDLE.
- Latency: if start is sampled at edge T0, done is high in the cycle following edge T0+18*CLK_DIV+1. Exactly 8 SCLK rising edges occur per transfer.
- Simultaneous events:
  - start during busy=1 is ignored; latched tx_data and slave_sel are unaffected.
  - start in the done cycle (busy=0) is accepted. The next transfer begins with no idle gap beyond that cycle.
- slave_sel and tx_data changes after acceptance have no effect.
- rx_data changes only in the done cycle; a rejected start leaves it unchanged.
- Reset mid-transfer:
  - No done pulse; rx_data=0.
  - A partially shifted slave sees cs_n rise and must be re-initialised by its owner.

Test Plan:
- Loopback (mosi tied to miso), CLK_DIV=2, start with tx_data=8'hA5, slave_sel=0 -> exactly 8 sclk rising edges; cs_n=2'b10 throughout; rx_data=8'hA5; done 37 cycles after the start-sampling edge; busy low in the done cycle.
- Slave model preloaded with 8'h3C on cs_n[1], tx_data=8'h96, slave_sel=1 -> rx_data=8'h3C; slave holds 8'h96; cs_n[0] stays 1; mosi observed LSB first: 0,1,1,0,1,0,0,1.
- start pulsed again with tx_data=8'hFF at the 4th rising sclk -> ignored; current transfer completes with its original byte; only one done pulse.
- NUM_SLAVES=2, slave_sel=... invalid index (SEL_W=2, slave_sel=3) -> err high for 1 cycle; busy, cs_n, sclk unchanged; rx_data keeps its prior value.
- reset driven to 0 between rising edges 3 and 4 -> same-cycle cs_n=all 1, sclk=0, busy=0, rx_data=0; no done. A new start after release transfers correctly.
- CLK_DIV=1, start held high continuously with tx_data 8'h01 then 8'h80 -> two back-to-back transfers, each 19 cycles start-to-done; second accepted in the first done cycle; rx_data matches the loopback values.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Request/status handshake and SPI pin bundle between a requester, spi_master_ctrl and its slaves.
// The master modport is the controller's view; the slave modport is the environment's view.
interface spi_master_ctrl_if #(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = 1
);
  logic                  start;
  logic [SEL_W-1:0]      slave_sel;
  logic [7:0]            tx_data;
  logic [7:0]            rx_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [NUM_SLAVES-1:0] cs_n;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, slave_sel, tx_data, miso,
    output rx_data, busy, done, err, cs_n, sclk, mosi
  );

  modport slave (
    output start, slave_sel, tx_data, miso,
    input  rx_data, busy, done, err, cs_n, sclk, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master (CPOL=0, CPHA=1, LSB first, 8-bit) sequencing one byte per start to a selected slave.
// Start-to-done is 18*CLK_DIV+1 cycles; start is only sampled while idle, so requests during a transfer are dropped.
module spi_master_ctrl #(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = 1,
  parameter int CLK_DIV    = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_ctrl_if.master bus
);

  localparam int                CNT_W     = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(CLK_DIV);
  localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]            r_tx_sh, w_tx_sh_nxt;
  logic [7:0]            r_rx_sh, w_rx_sh_nxt;
  logic [7:0]            r_rx_data, w_rx_data_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic [NUM_SLAVES-1:0] r_cs_n, w_cs_n_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_mosi, w_mosi_nxt;

  logic                  w_sel_ok;
  logic [NUM_SLAVES-1:0] w_cs_sel;
  logic                  w_div_wrap;

  assign w_sel_ok   = ({1'b0, bus.slave_sel} < SEL_LIMIT);
  assign w_cs_sel   = ~(NUM_SLAVES'(1) << bus.slave_sel);
  assign w_div_wrap = (r_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cs_n    <= '1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx_sh   <= w_tx_sh_nxt;
      r_rx_sh   <= w_rx_sh_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_sh_nxt   = r_tx_sh;
    w_rx_sh_nxt   = r_rx_sh;
    w_rx_data_nxt = r_rx_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_cs_n_nxt    = r_cs_n;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_sel_ok) begin
            w_tx_sh_nxt   = bus.tx_data;
            w_rx_sh_nxt   = '0;
            w_cs_n_nxt    = w_cs_sel;
            w_busy_nxt    = 1'b1;
            w_sclk_nxt    = 1'b0;
            w_cnt_nxt     = '0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_SETUP;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (w_div_wrap) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_XFER;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Each half-period wrap is one SCLK edge: rising shifts out, falling samples in.
      S_XFER: begin
        if (w_div_wrap) begin
          w_cnt_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt  = 1'b1;
            w_mosi_nxt  = r_tx_sh[0];
            w_tx_sh_nxt = {1'b0, r_tx_sh[7:1]};
          end else begin
            w_sclk_nxt    = 1'b0;
            w_rx_sh_nxt   = {bus.miso, r_rx_sh[7:1]};
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            if (r_bit_cnt == 4'd7) begin
              w_state_nxt = S_HOLD;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Hold CS for CLK_DIV cycles after the last edge, then release in a separate done cycle.
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt     = '0;
          w_cs_n_nxt    = '1;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx_sh;
          w_mosi_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rx_data = r_rx_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.cs_n    = r_cs_n;
  assign bus.sclk    = r_sclk;
  assign bus.mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: randomized transfers against loopback or CPHA=1 slave models, plus
// invalid-select, mid-transfer reset and back-to-back (CLK_DIV=1) scenarios.
module tb_spi_master_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   rise_cnt;
  logic [7:0] mosi_byte;
  logic       loop_en;
  logic [7:0] preload [2];
  logic [7:0] last_rx;

  spi_master_ctrl_if #(.NUM_SLAVES(2), .SEL_W(2)) bus ();
  spi_master_ctrl_if #(.NUM_SLAVES(2), .SEL_W(1)) bus1 ();

  spi_master_ctrl #(.NUM_SLAVES(2), .SEL_W(2), .CLK_DIV(2)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  spi_master_ctrl #(.NUM_SLAVES(2), .SEL_W(1), .CLK_DIV(1)) u_dut_fast (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rise_cnt  = 0;
    mosi_byte = 8'h00;
  end
  always @(posedge bus.sclk) rise_cnt = rise_cnt + 1;
  always @(negedge bus.sclk) mosi_byte = {bus.mosi, mosi_byte[7:1]};

  // CPHA=1 slave: drive out on rising SCLK, capture on falling, reload from preload on CS assertion.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic [7:0] sreg;
    logic       so;
    initial begin
      sreg = 8'h00;
      so   = 1'b0;
    end
    always begin
      @(negedge bus.cs_n[g]);
      sreg = preload[g];
      so   = 1'b0;
      while (bus.cs_n[g] === 1'b0) begin
        @(bus.sclk or bus.cs_n[g]);
        if (bus.cs_n[g] === 1'b0) begin
          if (bus.sclk) so = sreg[0];
          else          sreg = {bus.mosi, sreg[7:1]};
        end
      end
    end
  end

  assign bus.miso  = loop_en ? bus.mosi :
                     (bus.cs_n[0] == 1'b0) ? g_slv[0].so :
                     (bus.cs_n[1] == 1'b0) ? g_slv[1].so : 1'b0;
  assign bus1.miso = bus1.mosi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transfer on the CLK_DIV=2 instance, with a stray start pulse injected mid-transfer.
  task automatic run_xfer(input logic [1:0] sel, input logic [7:0] tx, input logic lb,
                          input logic [7:0] pre);
    logic [7:0] exp_rx;
    logic [1:0] exp_cs;
    logic [7:0] slv_got;
    int c0, rise0, dcyc, k;
    logic cs_bad, err_seen;
    loop_en           = lb;
    preload[sel[0]]   = pre;
    exp_rx            = lb ? tx : pre;
    exp_cs            = ~(2'b01 << sel[0]);
    cs_bad            = 1'b0;
    err_seen          = 1'b0;
    dcyc              = -1;
    k                 = $urandom_range(2, 30);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.slave_sel = sel;
    bus.tx_data   = tx;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.slave_sel = 2'($urandom);
    bus.tx_data   = 8'($urandom);
    c0    = cyc;
    rise0 = rise_cnt;
    for (int i = 0; i < 60 && dcyc < 0; i++) begin
      @(negedge clk);
      if (i == k) begin
        bus.start     = 1'b1;
        bus.tx_data   = 8'hFF;
        bus.slave_sel = 2'($urandom);
      end else if (i == k + 1) begin
        bus.start = 1'b0;
      end
      if (bus.err) err_seen = 1'b1;
      if (bus.done) dcyc = cyc - c0;
      else if (bus.cs_n !== exp_cs || bus.busy !== 1'b1) cs_bad = 1'b1;
    end
    bus.start = 1'b0;
    chk("latency", dcyc, 37);
    chk("busy_in_done", bus.busy, 0);
    chk("rx_data", bus.rx_data, exp_rx);
    chk("cs_release", bus.cs_n, 2'b11);
    chk("cs_during_xfer", cs_bad, 0);
    chk("err_during_xfer", err_seen, 0);
    chk("sclk_rises", rise_cnt - rise0, 8);
    chk("mosi_bits", mosi_byte, tx);
    if (!lb) begin
      slv_got = sel[0] ? g_slv[1].sreg : g_slv[0].sreg;
      chk("slave_rx", slv_got, tx);
    end
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("mosi_idle", bus.mosi, 0);
    last_rx = exp_rx;
  endtask

  task automatic bad_sel(input logic [1:0] sel);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.slave_sel = sel;
    bus.tx_data   = 8'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("err_pulse", bus.err, 1);
    chk("err_busy", bus.busy, 0);
    chk("err_cs", bus.cs_n, 2'b11);
    chk("err_sclk", bus.sclk, 0);
    chk("err_rx", bus.rx_data, last_rx);
    @(negedge clk);
    chk("err_one_cycle", bus.err, 0);
    chk("err_still_idle", bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, d1, d2, rise0;
    logic seen;
    n_cmp          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    loop_en        = 1'b1;
    preload[0]     = 8'h00;
    preload[1]     = 8'h00;
    last_rx        = 8'h00;
    bus.start      = 1'b0;
    bus.slave_sel  = '0;
    bus.tx_data    = '0;
    bus1.start     = 1'b0;
    bus1.slave_sel = '0;
    bus1.tx_data   = '0;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus.cs_n, 2'b11);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rx", bus.rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(2'd0, 8'hA5, 1'b1, 8'h00);
    run_xfer(2'd1, 8'h96, 1'b0, 8'h3C);
    bad_sel(2'd3);
    bad_sel(2'd2);

    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 4) == 0) bad_sel({1'b1, 1'($urandom)});
      else run_xfer({1'b0, 1'($urandom)}, 8'($urandom), 1'($urandom), 8'($urandom));
    end

    // Reset between rising SCLK edges 3 and 4.
    loop_en = 1'b1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.slave_sel = 2'd0;
    bus.tx_data   = 8'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rise0     = rise_cnt;
    for (int i = 0; i < 100 && (rise_cnt - rise0) < 3; i++) @(negedge clk);
    chk("rst_reach_r3", rise_cnt - rise0, 3);
    for (int i = 0; i < 10 && bus.sclk; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", bus.cs_n, 2'b11);
    chk("mid_rst_sclk", bus.sclk, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rx", bus.rx_data, 0);
    chk("mid_rst_done", bus.done, 0);
    last_rx = 8'h00;
    seen    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("mid_rst_no_done", seen, 0);
    chk("mid_rst_rx_held", bus.rx_data, 0);
    run_xfer(2'd0, 8'($urandom), 1'b1, 8'h00);
    run_xfer(2'd1, 8'($urandom), 1'b0, 8'($urandom));

    // CLK_DIV=1, start held high: second transfer accepted in the first done cycle.
    @(negedge clk);
    bus1.start     = 1'b1;
    bus1.slave_sel = 1'b0;
    bus1.tx_data   = 8'h01;
    @(posedge clk);
    #1;
    c0           = cyc;
    bus1.tx_data = 8'h80;
    d1           = -1;
    d2           = -1;
    for (int i = 0; i < 80 && d2 < 0; i++) begin
      @(negedge clk);
      if (bus1.done) begin
        if (d1 < 0) begin
          d1 = cyc - c0;
          chk("b2b_rx1", bus1.rx_data, 8'h01);
          chk("b2b_busy1", bus1.busy, 0);
        end else begin
          d2 = cyc - c0;
          chk("b2b_rx2", bus1.rx_data, 8'h80);
        end
      end else if (d1 >= 0 && (cyc - c0) == d1 + 1) begin
        chk("b2b_no_gap", bus1.busy, 1);
        bus1.start = 1'b0;
      end
    end
    bus1.start = 1'b0;
    chk("b2b_lat1", d1, 19);
    chk("b2b_lat2", d2, 39);
    @(negedge clk);
    chk("b2b_idle", bus1.busy, 0);
    chk("b2b_cs_idle", bus1.cs_n, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
